// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX        = 4'd9;
    localparam int   SEC_TENS_MAX_DEF = 5;
    localparam int   MIN_TENS_MAX_DEF = 5;

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// One BCD digit that counts 0..MAX on enable; carry is combinational so
// a chain of these rolls over within the same sysClk edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic sysClk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output bcd_t digit,
    output logic carry
);

    bcd_t r_digit;

    always_ff @(posedge sysClk) begin
        if (reset || clr) begin
            r_digit <= '0;
        end else if (en) begin
            r_digit <= (r_digit == MAX) ? '0 : r_digit + 4'd1;
        end
    end

    assign digit = r_digit;
    assign carry = en && (r_digit == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// MM:SS stopwatch counting rising edges of the divided 1 Hz clock, with
// run/pause, clear and a lap freeze that shows a snapshot while counting on.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       tickIn,
    input  logic       startStop,
    input  logic       clear,
    input  logic       lapToggle,
    output logic [3:0] secOnes,
    output logic [3:0] secTens,
    output logic [3:0] minOnes,
    output logic [3:0] minTens,
    output logic       running,
    output logic       lapActive,
    output logic       wrapPulse
);

    state_t r_state;
    state_t w_nextState;

    logic r_tickPrev;
    logic w_tickRise;
    logic w_countEn;
    logic w_lapFlip;

    bcd_t w_secOnes, w_secTens, w_minOnes, w_minTens;
    logic w_carrySO, w_carryST, w_carryMO, w_carryMT;

    logic r_lapActive;
    logic r_wrapPulse;
    bcd_t r_snapSecOnes, r_snapSecTens, r_snapMinOnes, r_snapMinTens;

    // Counting uses the registered state, so a start pulse never counts its own tick.
    assign w_tickRise = tickIn & ~r_tickPrev;
    assign w_countEn  = w_tickRise && (r_state == RUN) && !clear;
    assign w_lapFlip  = lapToggle && (r_state != IDLE) && !clear;

    always_ff @(posedge sysClk) begin
        if (reset) begin
            r_tickPrev <= 1'b0;
            r_state    <= IDLE;
        end else begin
            r_tickPrev <= tickIn;
            r_state    <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (clear) begin
            w_nextState = IDLE;
        end else if (startStop) begin
            case (r_state)
                IDLE:    w_nextState = RUN;
                RUN:     w_nextState = PAUSE;
                PAUSE:   w_nextState = RUN;
                default: w_nextState = IDLE;
            endcase
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_secOnes (
        .sysClk(sysClk), .reset(reset), .clr(clear), .en(w_countEn),
        .digit(w_secOnes), .carry(w_carrySO)
    );

    bcd_digit_counter #(.MAX(bcd_t'(SEC_TENS_MAX))) u_secTens (
        .sysClk(sysClk), .reset(reset), .clr(clear), .en(w_carrySO),
        .digit(w_secTens), .carry(w_carryST)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_minOnes (
        .sysClk(sysClk), .reset(reset), .clr(clear), .en(w_carryST),
        .digit(w_minOnes), .carry(w_carryMO)
    );

    bcd_digit_counter #(.MAX(bcd_t'(MIN_TENS_MAX))) u_minTens (
        .sysClk(sysClk), .reset(reset), .clr(clear), .en(w_carryMO),
        .digit(w_minTens), .carry(w_carryMT)
    );

    // Snapshot is taken from the pre-edge live digits only when entering lap mode.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            r_lapActive   <= 1'b0;
            r_wrapPulse   <= 1'b0;
            r_snapSecOnes <= '0;
            r_snapSecTens <= '0;
            r_snapMinOnes <= '0;
            r_snapMinTens <= '0;
        end else begin
            r_wrapPulse <= w_carryMT;
            if (clear) begin
                r_lapActive <= 1'b0;
            end else if (w_lapFlip) begin
                r_lapActive <= ~r_lapActive;
                if (!r_lapActive) begin
                    r_snapSecOnes <= w_secOnes;
                    r_snapSecTens <= w_secTens;
                    r_snapMinOnes <= w_minOnes;
                    r_snapMinTens <= w_minTens;
                end
            end
        end
    end

    assign secOnes   = r_lapActive ? r_snapSecOnes : w_secOnes;
    assign secTens   = r_lapActive ? r_snapSecTens : w_secTens;
    assign minOnes   = r_lapActive ? r_snapMinOnes : w_minOnes;
    assign minTens   = r_lapActive ? r_snapMinTens : w_minTens;
    assign running   = (r_state == RUN);
    assign lapActive = r_lapActive;
    assign wrapPulse = r_wrapPulse;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench: the driver pushes reference-model expectations, a monitor
// pops and compares one entry after every sysClk edge.
module tb_stopwatch_time_counter;

    localparam int SEC_PER_MIN = 60;
    localparam int PERIOD      = 3600;

    logic       sysClk = 1'b0;
    logic       reset = 1'b0;
    logic       tickIn = 1'b0;
    logic       startStop = 1'b0;
    logic       clear = 1'b0;
    logic       lapToggle = 1'b0;
    logic [3:0] secOnes, secTens, minOnes, minTens;
    logic       running, lapActive, wrapPulse;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed time as plain seconds, state as 0=idle 1=run 2=pause.
    int mState = 0;
    int mTime  = 0;
    int mSnap  = 0;
    bit mPrev  = 1'b0;
    bit mLap   = 1'b0;
    bit mWrap  = 1'b0;

    logic [18:0] expQ[$];

    stopwatch_time_counter dut (
        .sysClk(sysClk), .reset(reset), .tickIn(tickIn), .startStop(startStop),
        .clear(clear), .lapToggle(lapToggle), .secOnes(secOnes), .secTens(secTens),
        .minOnes(minOnes), .minTens(minTens), .running(running),
        .lapActive(lapActive), .wrapPulse(wrapPulse)
    );

    always #5 sysClk = ~sysClk;

    function automatic logic [18:0] packExp(input int t, input bit run, input bit lap, input bit wrap);
        logic [3:0] mt, mo, st, so;
        mt = 4'(t / (10 * SEC_PER_MIN));
        mo = 4'((t / SEC_PER_MIN) % 10);
        st = 4'((t % SEC_PER_MIN) / 10);
        so = 4'(t % 10);
        return {mt, mo, st, so, run, lap, wrap};
    endfunction

    task automatic applyStimulus(input bit rst, input bit tk, input bit ss, input bit clr, input bit lp);
        bit rise;
        bit cnt;
        @(negedge sysClk);
        reset     = rst;
        tickIn    = tk;
        startStop = ss;
        clear     = clr;
        lapToggle = lp;
        rise = tk && !mPrev;
        if (rst) begin
            mState = 0; mTime = 0; mSnap = 0; mPrev = 0; mLap = 0; mWrap = 0;
        end else begin
            mPrev = tk;
            if (clr) begin
                mState = 0; mTime = 0; mLap = 0; mWrap = 0;
            end else begin
                cnt   = rise && (mState == 1);
                mWrap = cnt && (mTime == PERIOD - 1);
                if (lp && mState != 0) begin
                    if (!mLap) mSnap = mTime;
                    mLap = !mLap;
                end
                if (cnt) mTime = (mTime + 1) % PERIOD;
                if (ss) mState = (mState == 1) ? 2 : 1;
            end
        end
        expQ.push_back(packExp(mLap ? mSnap : mTime, mState == 1, mLap, mWrap));
    endtask

    task automatic tickPulse(input int hi, input int lo);
        repeat (hi) applyStimulus(0, 1, 0, 0, 0);
        repeat (lo) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input logic [18:0] expv);
        logic [18:0] act;
        act = {minTens, minOnes, secTens, secOnes, running, lapActive, wrapPulse};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL outputs @%0t: got %0d%0d:%0d%0d run=%b lap=%b wrap=%b, expected %0d%0d:%0d%0d run=%b lap=%b wrap=%b",
                     $time, act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                     expv[18:15], expv[14:11], expv[10:7], expv[6:3], expv[2], expv[1], expv[0]);
        end
    endtask

    initial begin
        forever begin
            @(posedge sysClk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit tk;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Start, then three long-held ticks -> 00:03.
        applyStimulus(0, 0, 1, 0, 0);
        repeat (3) tickPulse(10, 10);

        // Up to 00:59, then 01:00.
        repeat (56) tickPulse(1, 1);
        tickPulse(1, 1);

        // Pause: ticks ignored; resume: one tick counts.
        applyStimulus(0, 0, 1, 0, 0);
        repeat (4) tickPulse(1, 1);
        applyStimulus(0, 0, 1, 0, 0);
        tickPulse(1, 1);

        // Lap freeze while counting, then release.
        applyStimulus(0, 0, 0, 0, 1);
        repeat (5) tickPulse(1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 0);

        // Full hour so the counter passes 59:59 -> 00:00.
        repeat (PERIOD) tickPulse(1, 1);

        // Tick coincident with startStop in RUN counts; in PAUSE it does not.
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Clear + startStop + tick together, then reset mid-count.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (7) tickPulse(1, 1);
        applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (4) tickPulse(1, 1);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Randomized control and tick traffic.
        tk = 1'b0;
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) tk = ~tk;
            applyStimulus($urandom_range(0, 999) == 0, tk,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 199) == 0,
                          $urandom_range(0, 24) == 0);
        end

        repeat (2) applyStimulus(0, 0, 0, 0, 0);
        @(posedge sysClk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
